// File: rtl/alu_pkg.sv
// Shared ALU definitions: function encodings and the sweep checker state set.
package alu_pkg;

  // Function encodings used by every ALU block and bench.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  // Sweep checker control states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU: expected result for (a, b, op).
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  // Select the expected function; ADD keeps only the low WIDTH bits.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves y unassigned (no latch).
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD:  y = a + b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive (A, B) sweep of an ALU slice with reference comparison,
// error counting and first-failure capture.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [WIDTH-1:0]   y_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_fail_valid,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b,
  output logic [WIDTH-1:0]   first_fail_y
);

  localparam int                ERR_W    = 2 * WIDTH + 1;
  localparam logic [3:0]        SETTLE_C = 4'(SETTLE);
  localparam logic [WIDTH-1:0]  OPND_MAX = '1;
  localparam logic [WIDTH-1:0]  OPND_ONE = WIDTH'(1);

  state_e             state;
  op_e                op_q;
  logic [3:0]         settle_cnt;
  logic [WIDTH-1:0]   y_exp;
  logic               mismatch;
  logic               sample;
  logic               last_vec;
  logic [ERR_W-1:0]   err_next;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a  (a_out),
    .b  (b_out),
    .op (op_q),
    .y  (y_exp)
  );

  assign sample   = (state == RUN) && (settle_cnt == SETTLE_C);
  assign mismatch = (y_in != y_exp);
  assign last_vec = (a_out == OPND_MAX) && (b_out == OPND_MAX);
  assign err_next = err_count + ERR_W'(mismatch);

  // Sweep FSM: vector sequencing, settle timing, scoring and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= OP_AND;
      settle_cnt       <= '0;
      a_out            <= '0;
      b_out            <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
      first_fail_y     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= RUN;
            op_q             <= op_e'(op);
            settle_cnt       <= '0;
            a_out            <= '0;
            b_out            <= '0;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_a     <= '0;
            first_fail_b     <= '0;
            first_fail_y     <= '0;
          end
        end
        RUN: begin
          if (sample) begin
            settle_cnt <= '0;
            err_count  <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_a     <= a_out;
              first_fail_b     <= b_out;
              first_fail_y     <= y_in;
            end
            if (last_vec) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              a_out <= '0;
              b_out <= '0;
            end else begin
              b_out <= b_out + OPND_ONE;
              if (b_out == OPND_MAX) begin
                a_out <= a_out + OPND_ONE;
              end
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
